// File: rtl/key_scan_module_pkg.sv
// Shared definitions for the push-button scanner: FSM state encoding and
// default board timing constants for a 16 MHz system clock.
package key_scan_module_pkg;

  localparam int CNT_W = 24;

  // Debounce / hold FSM encoding.
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_CHK   = 3'd1,
    PRESSED     = 3'd2,
    LONG_HELD   = 3'd3,
    RELEASE_CHK = 3'd4
  } key_state_e;

  // Board timing at 16 MHz, in CLK cycles.
  localparam logic [CNT_W-1:0] T_DEBOUNCE_16M = 24'd320_000;    // 20 ms
  localparam logic [CNT_W-1:0] T_LONG_16M     = 24'd16_000_000; // 1 s
  localparam logic [CNT_W-1:0] T100MS_16M     = 24'd1_600_000;  // 100 ms

endpackage

// File: rtl/key_scan_module_if.sv
// Button-side signal bundle: raw key level in, debounced level and event
// pulses out. The scanner sits on the slave side.
interface key_scan_module_if;
  logic Key_In;      // raw level, active-low, asynchronous
  logic Key_State;   // debounced level, 1 = pressed
  logic Key_Press;   // one-cycle pulse on accepted press
  logic Key_Release; // one-cycle pulse on accepted release
  logic Key_Long;    // one-cycle pulse after a long hold

  modport master (
    output Key_In,
    input  Key_State, Key_Press, Key_Release, Key_Long
  );

  modport slave (
    input  Key_In,
    output Key_State, Key_Press, Key_Release, Key_Long
  );
endinterface

// File: rtl/key_scan_module_sync2.sv
// Two-flop synchronizer for a single asynchronous level input. The reset
// value is a parameter so idle-high and idle-low inputs both come out of
// reset in their inactive level.
module sync2_module #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Two-stage capture; only the second stage is consumed downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/key_scan_module.sv
// Push-button scanner: synchronizes the raw active-low key, debounces it in
// both directions and emits single-cycle press / release / long-press
// events. Short dips during a hold are absorbed in RELEASE_CHK; the hold
// counter freezes there and resumes when the key settles low again.
module key_scan_module
  import key_scan_module_pkg::*;
#(
  parameter logic [CNT_W-1:0] T_DEBOUNCE = T_DEBOUNCE_16M,
  parameter logic [CNT_W-1:0] T_LONG     = T_LONG_16M
) (
  input  logic               CLK,
  input  logic               RST,
  key_scan_module_if.slave   key
);

  localparam logic [CNT_W-1:0] L_DEB_LAST  = T_DEBOUNCE - 24'd1;
  localparam logic [CNT_W-1:0] L_LONG_LAST = T_LONG - 24'd1;

  logic             w_s2;      // synchronized key level, 0 = pressed

  key_state_e       r_state,     w_state;
  logic [CNT_W-1:0] r_dcnt,      w_dcnt;
  logic [CNT_W-1:0] r_hcnt,      w_hcnt;
  logic             r_long_done, w_long_done;
  logic             r_key_state, w_key_state;
  logic             r_press,     w_press;
  logic             r_release,   w_release;
  logic             r_long,      w_long;

  // Raw key comes out of reset as "released" (high).
  sync2_module #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (key.Key_In),
    .o_q   (w_s2)
  );

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_dcnt      <= '0;
      r_hcnt      <= '0;
      r_long_done <= 1'b0;
      r_key_state <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_dcnt      <= w_dcnt;
      r_hcnt      <= w_hcnt;
      r_long_done <= w_long_done;
      r_key_state <= w_key_state;
      r_press     <= w_press;
      r_release   <= w_release;
      r_long      <= w_long;
    end
  end

  // Next-state, counter and event decode; pulses default low every cycle.
  always_comb begin
    w_state     = r_state;
    w_dcnt      = r_dcnt;
    w_hcnt      = r_hcnt;
    w_long_done = r_long_done;
    w_key_state = r_key_state;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;

    case (r_state)
      IDLE: begin
        w_key_state = 1'b0;
        if (!w_s2) begin
          w_state = PRESS_CHK;
          w_dcnt  = '0;
        end
      end

      PRESS_CHK: begin
        if (w_s2) begin
          // Bounce: key went high before the debounce window closed.
          w_state = IDLE;
        end else if (r_dcnt == L_DEB_LAST) begin
          w_state     = PRESSED;
          w_hcnt      = '0;
          w_press     = 1'b1;
          w_key_state = 1'b1;
          w_long_done = 1'b0;
        end else begin
          w_dcnt = r_dcnt + 24'd1;
        end
      end

      PRESSED: begin
        if (w_s2) begin
          // Hold counter is frozen while a possible release is checked.
          w_state = RELEASE_CHK;
          w_dcnt  = '0;
        end else if (r_hcnt == L_LONG_LAST) begin
          w_state     = LONG_HELD;
          w_long      = 1'b1;
          w_long_done = 1'b1;
        end else begin
          w_hcnt = r_hcnt + 24'd1;
        end
      end

      LONG_HELD: begin
        if (w_s2) begin
          w_state = RELEASE_CHK;
          w_dcnt  = '0;
        end
      end

      RELEASE_CHK: begin
        if (!w_s2) begin
          // Dip only: go back to where the hold left off.
          w_state = r_long_done ? LONG_HELD : PRESSED;
        end else if (r_dcnt == L_DEB_LAST) begin
          w_state     = IDLE;
          w_release   = 1'b1;
          w_key_state = 1'b0;
        end else begin
          w_dcnt = r_dcnt + 24'd1;
        end
      end

      default: begin
        w_state     = IDLE;
        w_key_state = 1'b0;
      end
    endcase
  end

  assign key.Key_State   = r_key_state;
  assign key.Key_Press   = r_press;
  assign key.Key_Release = r_release;
  assign key.Key_Long    = r_long;

endmodule
